// File: rtl/loader_pkg.sv
// Shared types and default constants for the UART word assembler slice.
package loader_pkg;

    // Publish FSM states
    typedef enum logic [1:0] {
        StIdle,
        StPublish,
        StGap
    } pub_state_e;

    localparam int unsigned DefValidStretch  = 2;
    localparam int unsigned DefMaxWords      = 8;
    localparam int unsigned DefTimeoutCycles = 5_000_000;

endpackage

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle of the UART word assembler.
// master: UART receiver side plus whoever consumes the word; slave: the assembler.
interface uart_word_assembler_if
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DefMaxWords
);
    localparam int unsigned CountW = $clog2(MAX_WORDS + 1);

    logic              i_rx_valid;
    logic [7:0]        i_rx_byte;
    logic [31:0]       o_word;
    logic              o_word_valid;
    logic [1:0]        o_byte_count;
    logic [CountW-1:0] o_word_count;
    logic              o_full;
    logic              o_overrun;
    logic              o_timeout;

    modport master (
        output i_rx_valid,
        output i_rx_byte,
        input  o_word,
        input  o_word_valid,
        input  o_byte_count,
        input  o_word_count,
        input  o_full,
        input  o_overrun,
        input  o_timeout
    );

    modport slave (
        input  i_rx_valid,
        input  i_rx_byte,
        output o_word,
        output o_word_valid,
        output o_byte_count,
        output o_word_count,
        output o_full,
        output o_overrun,
        output o_timeout
    );

endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer: three-byte assembly register plus byte counter.
// The 4th byte is never stored; it is combined directly into word_o on the completing strobe.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        clear_i,
    output logic [1:0]  byte_count_o,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [23:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next-state: a strobe always wins over a clear request
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (rx_valid_i) begin
            unique case (cnt_q)
                2'd0:    asm_d = {16'h0000, rx_byte_i};
                2'd1:    asm_d[15:8] = rx_byte_i;
                2'd2:    asm_d[23:16] = rx_byte_i;
                default: asm_d = '0;
            endcase
            cnt_d = cnt_q + 2'd1;
        end else if (clear_i) begin
            asm_d = '0;
            cnt_d = '0;
        end
    end

    // Assembly state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end

    assign byte_count_o = cnt_q;
    assign word_done_o  = rx_valid_i && (cnt_q == 2'd3);
    assign word_o       = {rx_byte_i, asm_q};

endmodule

// File: rtl/uart_word_assembler.sv
// Collects UART bytes into 32-bit words and publishes each as a stretched valid level
// followed by a one-cycle gap. Optional inter-byte timeout: define UART_WORD_TIMEOUT_EN.
module uart_word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned VALID_STRETCH  = DefValidStretch,
    parameter int unsigned MAX_WORDS      = DefMaxWords,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_word_assembler_if.slave  bus
);

    localparam int unsigned CountW      = $clog2(MAX_WORDS + 1);
    localparam logic [2:0]  StretchInit = 3'(VALID_STRETCH - 1);

    if (VALID_STRETCH < 1 || VALID_STRETCH > 7 || MAX_WORDS < 1 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("uart_word_assembler: parameter out of range");
    end

    logic        word_done;
    logic [31:0] packed_word;
    logic [1:0]  byte_count;
    logic        clear_partial;
    logic        timeout_pulse;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .rx_valid_i   (bus.i_rx_valid),
        .rx_byte_i    (bus.i_rx_byte),
        .clear_i      (clear_partial),
        .byte_count_o (byte_count),
        .word_done_o  (word_done),
        .word_o       (packed_word)
    );

`ifdef UART_WORD_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            timeout_q;
    logic            tmo_expire;

    // Expiry only when a partial word is held and no byte arrives on this edge
    assign tmo_expire = !bus.i_rx_valid && (byte_count != 2'd0) &&
                        (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Inter-byte idle counter; parked at zero while no partial word is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (bus.i_rx_valid || byte_count == 2'd0 || tmo_expire) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
            end
            timeout_q <= tmo_expire;
        end
    end

    assign clear_partial = tmo_expire;
    assign timeout_pulse = timeout_q;
`else
    assign clear_partial = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    pub_state_e        state_q;
    logic [31:0]       word_q;
    logic              valid_q;
    logic [2:0]        stretch_q;
    logic [CountW-1:0] count_q;
    logic              full_q;
    logic              overrun_q;

    // Publish FSM with word counter and sticky flags; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            word_q    <= '0;
            valid_q   <= 1'b0;
            stretch_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (word_done && !full_q) begin
                        word_q    <= packed_word;
                        valid_q   <= 1'b1;
                        stretch_q <= StretchInit;
                        count_q   <= count_q + CountW'(1);
                        full_q    <= (count_q == CountW'(MAX_WORDS - 1));
                        state_q   <= StPublish;
                    end
                end
                StPublish: begin
                    // Completion while busy is dropped; once full, drops are silent
                    if (word_done && !full_q) begin
                        overrun_q <= 1'b1;
                    end
                    if (stretch_q == 3'd0) begin
                        valid_q <= 1'b0;
                        state_q <= StGap;
                    end else begin
                        stretch_q <= stretch_q - 3'd1;
                    end
                end
                StGap: begin
                    if (word_done && !full_q) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_word       = word_q;
    assign bus.o_word_valid = valid_q;
    assign bus.o_byte_count = byte_count;
    assign bus.o_word_count = count_q;
    assign bus.o_full       = full_q;
    assign bus.o_overrun    = overrun_q;
    assign bus.o_timeout    = timeout_pulse;

endmodule

// File: doc/uart_word_assembler.md
UART_WORD_ASSEMBLER -- requirements
Module: uart_word_assembler

Interface
REQ-001 Parameter VALID_STRETCH, default 2: number of cycles o_word_valid is held high per word (legal range 1..7).
REQ-002 Parameter MAX_WORDS, default 8: number of words published before the block stops publishing.
REQ-003 Parameter TIMEOUT_CYCLES, default 5_000_000: inter-byte timeout in clk cycles; used only when UART_WORD_TIMEOUT_EN is defined.
REQ-004 clk  input  1  system clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 i_rx_valid  input  1  one-cycle strobe from the UART receiver marking a valid byte.
REQ-007 i_rx_byte  input  8  received byte; sampled only when i_rx_valid=1.
REQ-008 o_word  output  32  last completed instruction word.
REQ-009 o_word_valid  output  1  word-ready level, high for VALID_STRETCH cycles per word.
REQ-010 o_byte_count  output  2  number of bytes held in the partial word (0..3).
REQ-011 o_word_count  output  $clog2(MAX_WORDS+1)  number of words published so far.
REQ-012 o_full  output  1  high once o_word_count equals MAX_WORDS.
REQ-013 o_overrun  output  1  sticky flag: a word completed while the previous publish was still in progress.
REQ-014 o_timeout  output  1  one-cycle pulse when a partial word is discarded.

Function
REQ-015 Byte order is little-endian: the 1st byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24].
REQ-016 The assembly register and byte counter update on every i_rx_valid, independent of the publish FSM.
REQ-017 When the 4th byte is accepted, the byte counter wraps to 0 and the word completes on that edge.
REQ-018 FSM states: IDLE, PUBLISH, GAP.
REQ-019 Transition IDLE->PUBLISH occurs on word completion when o_full=0; on the same edge o_word is loaded and o_word_valid rises (1-cycle latency from the 4th strobe).
REQ-020 PUBLISH lasts VALID_STRETCH cycles, then goes to GAP, and o_word_valid falls.
REQ-021 GAP lasts exactly 1 cycle with o_word_valid=0, then returns to IDLE; this guarantees a low-to-high edge for the downstream loader's edge detector.
REQ-022 o_word holds its value from load until the next publish and never changes during PUBLISH or GAP.
REQ-023 o_word_count increments by 1 on each IDLE->PUBLISH transition and saturates at MAX_WORDS.
REQ-024 A word completing in PUBLISH or GAP is dropped: o_word is unchanged and o_overrun is set.
REQ-025 A word completing while o_full=1 is dropped silently: no publish, and o_overrun is not set.
REQ-026 A byte strobe in the same cycle as a publish-state transition is accepted normally.

Reset
REQ-027 Asserting rst at any time forces the FSM to IDLE and clears to 0: o_word, o_word_valid, o_byte_count, o_word_count, o_full, o_overrun, o_timeout, the assembly register, and the timeout counter.
REQ-028 Reset asserted mid-word or mid-publish abandons that word; the first byte after release goes to [7:0].

Configuration
REQ-029 With UART_WORD_TIMEOUT_EN defined, a counter restarts on each i_rx_valid while o_byte_count≠0.
REQ-030 With UART_WORD_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES with no strobe clears o_byte_count and the assembly register and pulses o_timeout for 1 cycle.
REQ-031 With UART_WORD_TIMEOUT_EN defined, a strobe in the expiry cycle takes priority: the byte is accepted and no timeout occurs.
REQ-032 Without UART_WORD_TIMEOUT_EN, no counter is built, o_timeout is tied 0, and partial words persist indefinitely.

Structure
REQ-033 FSM state encodings and the default constants (VALID_STRETCH, MAX_WORDS, TIMEOUT_CYCLES) reside in the shared package loader_pkg.
REQ-034 Byte-to-word packing is the sub-module byte_packer (assembly register plus byte counter); the FSM, word counter, and flags stay in the top level.

Verification
REQ-035 Bytes 0x13,0x05,0x10,0x00 -> 1 cycle after the 4th strobe, o_word=0x00100513, o_word_valid=1 for 2 cycles then low, o_word_count=1.
REQ-036 9 words sent back-to-back at UART pacing -> words 1..8 published, o_full=1 after the 8th, 9th word not published, o_word holds word 8, o_overrun=0.
REQ-037 4th byte strobes arriving 1 cycle after the previous publish begins (forced fast stimulus) -> second word dropped, o_overrun=1 until reset.
REQ-038 rst pulsed after 2 bytes, then bytes 0xAA,0xBB,0xCC,0xDD -> o_word=0xDDCCBBAA.
REQ-039 With UART_WORD_TIMEOUT_EN and TIMEOUT_CYCLES=100: 3 bytes then 100 idle cycles -> o_timeout pulses, o_byte_count=0, and next 4 bytes form a clean word.
REQ-040 Downstream loader model attached -> exactly one write per published word, addresses 0..7, each data matching o_word.
